led_pwm_peripheral: RTL

LED_PWM_PERIPHERAL -- requirements
Module: led_pwm_peripheral

---
 rtl/led_pwm_peripheral_pkg.sv | 39 +++
 rtl/led_pwm_peripheral_if.sv | 25 ++
 rtl/led_pwm_peripheral_timebase.sv | 37 +++
 rtl/led_pwm_peripheral.sv | 129 ++++++++++++
 4 files changed

// File: rtl/led_pwm_peripheral_pkg.sv
// Shared definitions for the LED PWM peripheral: the register offsets, the
// CTRL field positions, the PERIOD width and the address decoder.
package led_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_CTRL   = 4'h4;
  localparam logic [3:0] ADDR_PERIOD = 4'h8;
  localparam logic [3:0] ADDR_TOGGLE = 4'hC;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLINK_BIT = 1;
  localparam int CTRL_DUTY_LSB  = 8;

  localparam int PERIOD_W = 16;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_CTRL,
    SEL_PERIOD,
    SEL_STATUS
  } reg_sel_e;

  // Only the four word-aligned offsets are mapped; every other nibble selects
  // nothing, so writes there are dropped and reads return 0.
  function automatic reg_sel_e decode_addr(input logic [3:0] addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    case (addr)
      ADDR_DATA:   sel = SEL_DATA;
      ADDR_CTRL:   sel = SEL_CTRL;
      ADDR_PERIOD: sel = SEL_PERIOD;
      ADDR_TOGGLE: sel = SEL_STATUS;
      default:     sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/led_pwm_peripheral_if.sv
// Register bus between a host and the LED PWM peripheral. Reads are
// combinational; a write happens on every cycle wr_en_i is high.
interface led_pwm_peripheral_if;
  logic        rd_en_i;
  logic        wr_en_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output rd_en_i,
    output wr_en_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  rd_en_i,
    input  wr_en_i,
    input  addr_i,
    input  data_i,
    output data_o
  );
endinterface

// File: rtl/led_pwm_peripheral_timebase.sv
// Free-running PWM timebase: a prescaler that produces one tick every
// PRESCALE clocks, and the PWM counter that advances on each tick. Register
// writes never reach this block, so the timebase phase only restarts on reset.
module pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                tick,
  output logic                period_end,
  output logic [PWM_BITS-1:0] pwm_cnt
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;

  // With PRESCALE=1 the prescaler sits at 0 and tick is high every cycle.
  assign tick       = (ps_cnt == PS_LAST);
  assign period_end = tick && (pwm_cnt == '1);

  // Prescaler wraps on tick; the PWM counter advances (and wraps) on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt  <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      ps_cnt  <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      ps_cnt  <= ps_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_peripheral.sv
// LED PWM peripheral: a small register file (DATA, CTRL, PERIOD,
// TOGGLE/STATUS), a PWM comparator fed by the shared timebase, and a blink
// divider that gates all LEDs on/off every PERIOD PWM periods.
module led_pwm_peripheral #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  led_pwm_peripheral_if.slave bus,
  output logic [NUM_LEDS-1:0] leds_o
);
  import led_pkg::*;

  logic [NUM_LEDS-1:0] data_q;
  logic                en_q;
  logic                blink_en_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] blink_cnt;
  logic                phase_q;

  logic                tick_unused;
  logic                period_end;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic                blink_active;
  reg_sel_e            sel;
  logic                wr_ctrl;
  logic                wr_period;
  logic [31:0]         rdata;
  logic                unused_bits;

  pwm_timebase #(
    .PWM_BITS(PWM_BITS),
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick_unused),
    .period_end(period_end),
    .pwm_cnt   (pwm_cnt)
  );

  assign sel       = decode_addr(bus.addr_i[3:0]);
  assign wr_ctrl   = bus.wr_en_i && (sel == SEL_CTRL);
  assign wr_period = bus.wr_en_i && (sel == SEL_PERIOD);

  // Full-scale duty means "always on" so the top code is not one step short.
  assign pwm_on       = (duty_q == '1) || (pwm_cnt < duty_q);
  assign blink_active = blink_en_q && (period_q != '0);

  assign unused_bits = ^{bus.addr_i[31:4], bus.data_i, tick_unused};

  // Register file writes; unused bits of each register are simply not stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      en_q       <= 1'b0;
      blink_en_q <= 1'b0;
      duty_q     <= '0;
      period_q   <= '0;
    end else if (bus.wr_en_i) begin
      case (sel)
        SEL_DATA:   data_q <= bus.data_i[NUM_LEDS-1:0];
        SEL_CTRL: begin
          en_q       <= bus.data_i[CTRL_EN_BIT];
          blink_en_q <= bus.data_i[CTRL_BLINK_BIT];
          duty_q     <= bus.data_i[CTRL_DUTY_LSB +: PWM_BITS];
        end
        SEL_PERIOD: period_q <= bus.data_i[PERIOD_W-1:0];
        SEL_STATUS: data_q <= data_q ^ bus.data_i[NUM_LEDS-1:0];
        default: ;
      endcase
    end
  end

  // Blink divider; a CTRL/PERIOD write restarts the blink cycle lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase_q   <= 1'b1;
    end else if (wr_ctrl || wr_period || !blink_active) begin
      blink_cnt <= '0;
      phase_q   <= 1'b1;
    end else if (period_end) begin
      if (blink_cnt == period_q - PERIOD_W'(1)) begin
        blink_cnt <= '0;
        phase_q   <= ~phase_q;
      end else begin
        blink_cnt <= blink_cnt + PERIOD_W'(1);
      end
    end
  end

  // Registered LED drive from the current register and PWM/blink state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_o <= '0;
    end else begin
      leds_o <= data_q & {NUM_LEDS{en_q & pwm_on & phase_q}};
    end
  end

  // Combinational read mux, forced to 0 when no read is strobed.
  always_comb begin
    rdata = '0;
    if (bus.rd_en_i) begin
      case (sel)
        SEL_DATA:   rdata[NUM_LEDS-1:0] = data_q;
        SEL_CTRL: begin
          rdata[CTRL_EN_BIT]                  = en_q;
          rdata[CTRL_BLINK_BIT]               = blink_en_q;
          rdata[CTRL_DUTY_LSB +: PWM_BITS]    = duty_q;
        end
        SEL_PERIOD: rdata[PERIOD_W-1:0] = period_q;
        SEL_STATUS: begin
          rdata[0]                         = phase_q;
          rdata[CTRL_DUTY_LSB +: PWM_BITS] = pwm_cnt;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_o = rdata;

endmodule
